pipeline_ctrl_unit: RTL and testbench

Parametrised successor to the single-cycle control decoder. It decodes the ID-stage instruction, carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers, and generates load-use interlock, branch/jump flush and external-stall freeze. It also keeps saturating performance counters for stall and flush cycles. It sits between the IF/ID register and the EX/MEM/WB datapath of the pipelined core.

---
 rtl/pipeline_ctrl_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use interlock, redirect flush, external freeze and saturating event counters.
module pipeline_ctrl_unit #(
    parameter int unsigned REG_ADDR_W     = 5,
    parameter bit          ENABLE_JUMP    = 1'b1,
    parameter bit          LOAD_USE_STALL = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic                  ex_redirect,
    input  logic                  stall_ext,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_alu_op,
    output logic [1:0]            ex_wb_sel,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [1:0]            mem_wb_sel,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_wb_sel,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [1:0]            alu_op;
        logic [1:0]            wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [1:0]            wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } memwb_t;

    idex_t            idex_q, idex_d, dec;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             use_rs1, use_rs2, load_use, stall_evt, flush_evt;
    logic [6:0]       opcode;
    logic [REG_ADDR_W-1:0] id_rd, id_rs1, id_rs2;
    logic             unused_instr_bits;

    assign opcode            = id_instr[6:0];
    assign id_rd             = REG_ADDR_W'(id_instr[11:7]);
    assign id_rs1            = REG_ADDR_W'(id_instr[19:15]);
    assign id_rs2            = REG_ADDR_W'(id_instr[24:20]);
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

    // Opcode decode; invalid slot or unknown opcode yields a bubble
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_R: begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 2'b10;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OP_I: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = 2'b10;
                    use_rs1       = 1'b1;
                end
                OP_LD: begin
                    dec.reg_write = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.wb_sel    = 2'b01;
                    use_rs1       = 1'b1;
                end
                OP_ST: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OP_BR: begin
                    dec.branch = 1'b1;
                    dec.alu_op = 2'b01;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OP_JAL, OP_JALR: begin
                    if (ENABLE_JUMP) begin
                        dec.reg_write = 1'b1;
                        dec.jump      = 1'b1;
                        dec.alu_src   = 1'b1;
                        dec.wb_sel    = 2'b10;
                        use_rs1       = (opcode == OP_JALR);
                    end
                end
                default: ;
            endcase
        end
        dec.rd = dec.reg_write ? id_rd : '0;
    end

    // Hazard priority: external freeze, then redirect flush, then load-use bubble
    always_comb begin
        load_use = LOAD_USE_STALL && id_valid && idex_q.mem_read && (idex_q.rd != '0) &&
                   ((use_rs1 && (id_rs1 == idex_q.rd)) || (use_rs2 && (id_rs2 == idex_q.rd)));

        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        idex_d     = dec;

        exmem_d.reg_write = idex_q.reg_write;
        exmem_d.mem_read  = idex_q.mem_read;
        exmem_d.mem_write = idex_q.mem_write;
        exmem_d.wb_sel    = idex_q.wb_sel;
        exmem_d.rd        = idex_q.rd;

        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.wb_sel    = exmem_q.wb_sel;
        memwb_d.rd        = exmem_q.rd;

        if (stall_ext) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_d     = idex_q;
            exmem_d    = exmem_q;
            memwb_d    = memwb_q;
            stall_evt  = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_d     = '0;
            flush_evt  = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_d     = '0;
            stall_evt  = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_branch     = idex_q.branch;
    assign ex_jump       = idex_q.jump;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_wb_sel     = idex_q.wb_sel;
    assign ex_rd         = idex_q.rd;
    assign mem_reg_write = exmem_q.reg_write;
    assign mem_mem_read  = exmem_q.mem_read;
    assign mem_mem_write = exmem_q.mem_write;
    assign mem_wb_sel    = exmem_q.wb_sel;
    assign mem_rd        = exmem_q.rd;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_wb_sel     = memwb_q.wb_sel;
    assign wb_rd         = memwb_q.rd;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: default instance plus a no-interlock/no-jump/4-bit-counter instance,
// both checked against a pipeline model; hand vectors and corner sequences on top.
module tb_pipeline_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, ex_redirect, stall_ext;
    logic [31:0] id_instr;

    logic a_pc_w, a_ifid_w, a_flush, a_ex_rw, a_ex_mr, a_ex_mw, a_ex_br, a_ex_jp, a_ex_as;
    logic a_mem_rw, a_mem_mr, a_mem_mw, a_wb_rw;
    logic [1:0] a_ex_aop, a_ex_wb, a_mem_wb, a_wb_wb;
    logic [4:0] a_ex_rd, a_mem_rd, a_wb_rd;
    logic [15:0] a_sc, a_fc;

    logic b_pc_w, b_ifid_w, b_flush, b_ex_rw, b_ex_mr, b_ex_mw, b_ex_br, b_ex_jp, b_ex_as;
    logic b_mem_rw, b_mem_mr, b_mem_mw, b_wb_rw;
    logic [1:0] b_ex_aop, b_ex_wb, b_mem_wb, b_wb_wb;
    logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;
    logic [3:0] b_sc, b_fc;

    pipeline_ctrl_unit dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .stall_ext(stall_ext),
        .pc_write(a_pc_w), .ifid_write(a_ifid_w), .ifid_flush(a_flush),
        .ex_reg_write(a_ex_rw), .ex_mem_read(a_ex_mr), .ex_mem_write(a_ex_mw),
        .ex_branch(a_ex_br), .ex_jump(a_ex_jp), .ex_alu_src(a_ex_as),
        .ex_alu_op(a_ex_aop), .ex_wb_sel(a_ex_wb), .ex_rd(a_ex_rd),
        .mem_reg_write(a_mem_rw), .mem_mem_read(a_mem_mr), .mem_mem_write(a_mem_mw),
        .mem_wb_sel(a_mem_wb), .mem_rd(a_mem_rd),
        .wb_reg_write(a_wb_rw), .wb_wb_sel(a_wb_wb), .wb_rd(a_wb_rd),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipeline_ctrl_unit #(
        .REG_ADDR_W(5), .ENABLE_JUMP(1'b0), .LOAD_USE_STALL(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .stall_ext(stall_ext),
        .pc_write(b_pc_w), .ifid_write(b_ifid_w), .ifid_flush(b_flush),
        .ex_reg_write(b_ex_rw), .ex_mem_read(b_ex_mr), .ex_mem_write(b_ex_mw),
        .ex_branch(b_ex_br), .ex_jump(b_ex_jp), .ex_alu_src(b_ex_as),
        .ex_alu_op(b_ex_aop), .ex_wb_sel(b_ex_wb), .ex_rd(b_ex_rd),
        .mem_reg_write(b_mem_rw), .mem_mem_read(b_mem_mr), .mem_mem_write(b_mem_mw),
        .mem_wb_sel(b_mem_wb), .mem_rd(b_mem_rd),
        .wb_reg_write(b_wb_rw), .wb_wb_sel(b_wb_wb), .wb_rd(b_wb_rd),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    typedef struct packed {
        logic pc_w, ifid_w, flush;
        logic ex_rw, ex_mr, ex_mw, ex_br, ex_jp, ex_as;
        logic [1:0] ex_aop, ex_wb;
        logic [4:0] ex_rd;
        logic mem_rw, mem_mr, mem_mw;
        logic [1:0] mem_wb;
        logic [4:0] mem_rd;
        logic wb_rw;
        logic [1:0] wb_wb;
        logic [4:0] wb_rd;
        logic [15:0] sc, fc;
    } obs_t;

    obs_t obs_a, obs_b;
    assign obs_a = {a_pc_w, a_ifid_w, a_flush, a_ex_rw, a_ex_mr, a_ex_mw, a_ex_br, a_ex_jp, a_ex_as,
                    a_ex_aop, a_ex_wb, a_ex_rd, a_mem_rw, a_mem_mr, a_mem_mw, a_mem_wb, a_mem_rd,
                    a_wb_rw, a_wb_wb, a_wb_rd, a_sc, a_fc};
    assign obs_b = {b_pc_w, b_ifid_w, b_flush, b_ex_rw, b_ex_mr, b_ex_mw, b_ex_br, b_ex_jp, b_ex_as,
                    b_ex_aop, b_ex_wb, b_ex_rd, b_mem_rw, b_mem_mr, b_mem_mw, b_mem_wb, b_mem_rd,
                    b_wb_rw, b_wb_wb, b_wb_rd, 12'd0, b_sc, 12'd0, b_fc};

    // Reference model: one control record per stage, per configuration
    typedef struct packed {
        logic rw, mr, mw, br, jp, as;
        logic [1:0] aop, wb;
        logic [4:0] rd;
    } mc_t;

    mc_t m_ex[2], m_mem[2], m_wb[2];
    int  m_sc[2], m_fc[2];
    int  cfg_max[2] = '{65535, 15};
    bit  cfg_lus[2] = '{1'b1, 1'b0};
    bit  cfg_ej[2]  = '{1'b1, 1'b0};

    int  n_chk = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                           OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    // Control word per instruction class: RegWrite MemRead MemWrite Branch Jump ALUSrc ALUOp wb_sel
    function automatic void decode(input logic v, input logic [31:0] ins, input bit ej,
                                   output mc_t c, output bit u1, output bit u2);
        logic [9:0] w;
        w = 10'b0; u1 = 1'b0; u2 = 1'b0;
        if (v) begin
            case (ins[6:0])
                OPC_R:    begin w = 10'b1000001000; u1 = 1'b1; u2 = 1'b1; end
                OPC_I:    begin w = 10'b1000011000; u1 = 1'b1; end
                OPC_LD:   begin w = 10'b1100010001; u1 = 1'b1; end
                OPC_ST:   begin w = 10'b0010010000; u1 = 1'b1; u2 = 1'b1; end
                OPC_BR:   begin w = 10'b0001000100; u1 = 1'b1; u2 = 1'b1; end
                OPC_JAL:  if (ej) w = 10'b1000110010;
                OPC_JALR: if (ej) begin w = 10'b1000110010; u1 = 1'b1; end
                default:  ;
            endcase
        end
        c = {w, 5'd0};
        if (c.rw) c.rd = ins[11:7];
    endfunction

    function automatic bit load_use_of(input int k);
        mc_t d; bit u1, u2;
        decode(id_valid, id_instr, cfg_ej[k], d, u1, u2);
        return cfg_lus[k] && id_valid && m_ex[k].mr && (m_ex[k].rd != 5'd0) &&
               ((u1 && id_instr[19:15] == m_ex[k].rd) || (u2 && id_instr[24:20] == m_ex[k].rd));
    endfunction

    function automatic obs_t predict(input int k);
        obs_t e; bit lu;
        lu = load_use_of(k);
        e = '0;
        e.pc_w   = !stall_ext && (ex_redirect || !lu);
        e.ifid_w = e.pc_w;
        e.flush  = !stall_ext && ex_redirect;
        e.ex_rw = m_ex[k].rw; e.ex_mr = m_ex[k].mr; e.ex_mw = m_ex[k].mw;
        e.ex_br = m_ex[k].br; e.ex_jp = m_ex[k].jp; e.ex_as = m_ex[k].as;
        e.ex_aop = m_ex[k].aop; e.ex_wb = m_ex[k].wb; e.ex_rd = m_ex[k].rd;
        e.mem_rw = m_mem[k].rw; e.mem_mr = m_mem[k].mr; e.mem_mw = m_mem[k].mw;
        e.mem_wb = m_mem[k].wb; e.mem_rd = m_mem[k].rd;
        e.wb_rw = m_wb[k].rw; e.wb_wb = m_wb[k].wb; e.wb_rd = m_wb[k].rd;
        e.sc = 16'(m_sc[k]);
        e.fc = 16'(m_fc[k]);
        return e;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            mc_t d, nm, nw; bit u1, u2, lu;
            decode(id_valid, id_instr, cfg_ej[k], d, u1, u2);
            lu = load_use_of(k);
            if (rst) begin
                m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
            end else if (stall_ext) begin
                m_sc[k] = (m_sc[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_sc[k] + 1;
            end else begin
                nw = '0; nw.rw = m_mem[k].rw; nw.wb = m_mem[k].wb; nw.rd = m_mem[k].rd;
                nm = '0; nm.rw = m_ex[k].rw; nm.mr = m_ex[k].mr; nm.mw = m_ex[k].mw;
                nm.wb = m_ex[k].wb; nm.rd = m_ex[k].rd;
                m_wb[k]  = nw;
                m_mem[k] = nm;
                m_ex[k]  = (ex_redirect || lu) ? mc_t'('0) : d;
                if (ex_redirect)
                    m_fc[k] = (m_fc[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_fc[k] + 1;
                else if (lu)
                    m_sc[k] = (m_sc[k] + 1 > cfg_max[k]) ? cfg_max[k] : m_sc[k] + 1;
            end
        end
    endfunction

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    task automatic apply(input logic r, input logic v, input logic [31:0] ins,
                         input logic rd, input logic st);
        @(negedge clk);
        rst = r; id_valid = v; id_instr = ins; ex_redirect = rd; stall_ext = st;
        #1;
        if (chk_en) begin
            chk("model_a", 128'(obs_a), 128'(predict(0)));
            chk("model_b", 128'(obs_b), 128'(predict(1)));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
    endtask

    typedef struct {
        logic r, v; logic [31:0] ins; logic rd, st;
        logic pc_w, ifid_w, flush, ex_rw; logic [4:0] ex_rd, mem_rd;
        logic wb_rw; logic [4:0] wb_rd; int sc, fc;
    } vec_t;

    vec_t tbl[$];
    logic [6:0] ops[8] = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, 7'b1110011};

    initial begin
        logic [31:0] add3, lw5, add6, lw7, add8, add9, jal1, sw4, lw0, add2, ins;
        add3 = mk(OPC_R, 3, 1, 2);  lw5 = mk(OPC_LD, 5, 3, 0); add6 = mk(OPC_R, 6, 5, 1);
        lw7  = mk(OPC_LD, 7, 1, 0); add8 = mk(OPC_R, 8, 7, 7); add9 = mk(OPC_R, 9, 1, 2);
        jal1 = mk(OPC_JAL, 1, 0, 0); sw4 = mk(OPC_ST, 4, 1, 2); lw0 = mk(OPC_LD, 0, 1, 0);
        add2 = mk(OPC_R, 2, 0, 0);

        //               r  v  ins   rd st  pc ifw fl exrw exrd memrd wbrw wbrd sc fc
        tbl.push_back('{0, 0, 0,    0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, add3, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, lw5,  0, 0,  1, 1, 0, 1, 3, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, add6, 0, 0,  0, 0, 0, 1, 5, 3, 0, 0, 0, 0});
        tbl.push_back('{0, 1, add6, 0, 0,  1, 1, 0, 0, 0, 5, 1, 3, 1, 0});
        tbl.push_back('{0, 0, 0,    0, 0,  1, 1, 0, 1, 6, 0, 1, 5, 1, 0});
        tbl.push_back('{0, 1, lw7,  0, 0,  1, 1, 0, 0, 0, 6, 0, 0, 1, 0});
        tbl.push_back('{0, 1, add8, 1, 0,  1, 1, 1, 1, 7, 0, 1, 6, 1, 0});
        tbl.push_back('{0, 0, 0,    0, 0,  1, 1, 0, 0, 0, 7, 0, 0, 1, 1});
        tbl.push_back('{0, 1, add9, 0, 0,  1, 1, 0, 0, 0, 0, 1, 7, 1, 1});
        tbl.push_back('{0, 0, 0,    1, 1,  0, 0, 0, 1, 9, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0,    1, 1,  0, 0, 0, 1, 9, 0, 0, 0, 2, 1});
        tbl.push_back('{0, 0, 0,    1, 1,  0, 0, 0, 1, 9, 0, 0, 0, 3, 1});
        tbl.push_back('{0, 0, 0,    1, 0,  1, 1, 1, 1, 9, 0, 0, 0, 4, 1});
        tbl.push_back('{0, 0, 0,    0, 0,  1, 1, 0, 0, 0, 9, 0, 0, 4, 2});
        tbl.push_back('{0, 1, jal1, 0, 0,  1, 1, 0, 0, 0, 0, 1, 9, 4, 2});
        tbl.push_back('{0, 1, sw4,  0, 0,  1, 1, 0, 1, 1, 0, 0, 0, 4, 2});
        tbl.push_back('{0, 0, 0,    0, 0,  1, 1, 0, 0, 0, 1, 0, 0, 4, 2});
        tbl.push_back('{1, 0, 0,    0, 0,  1, 1, 0, 0, 0, 0, 1, 1, 4, 2});
        tbl.push_back('{0, 1, lw0,  0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, add2, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0});

        // Two reset cycles; the first edge is the one that defines the registers
        apply(1, 0, 0, 0, 0); advance();
        chk_en = 1'b1;
        apply(1, 0, 0, 0, 0); advance();

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].ins, tbl[i].rd, tbl[i].st);
            chk($sformatf("row%0d pc_write", i),     128'(a_pc_w),   128'(tbl[i].pc_w));
            chk($sformatf("row%0d ifid_write", i),   128'(a_ifid_w), 128'(tbl[i].ifid_w));
            chk($sformatf("row%0d ifid_flush", i),   128'(a_flush),  128'(tbl[i].flush));
            chk($sformatf("row%0d ex_reg_write", i), 128'(a_ex_rw),  128'(tbl[i].ex_rw));
            chk($sformatf("row%0d ex_rd", i),        128'(a_ex_rd),  128'(tbl[i].ex_rd));
            chk($sformatf("row%0d mem_rd", i),       128'(a_mem_rd), 128'(tbl[i].mem_rd));
            chk($sformatf("row%0d wb_reg_write", i), 128'(a_wb_rw),  128'(tbl[i].wb_rw));
            chk($sformatf("row%0d wb_rd", i),        128'(a_wb_rd),  128'(tbl[i].wb_rd));
            chk($sformatf("row%0d stall_cnt", i),    128'(a_sc),     128'(tbl[i].sc));
            chk($sformatf("row%0d flush_cnt", i),    128'(a_fc),     128'(tbl[i].fc));
            advance();
        end

        // Interlock disabled: the dependent add is not held back
        apply(0, 1, lw5, 0, 0); advance();
        apply(0, 1, add6, 0, 0);
        chk("lus_on pc_write", 128'(a_pc_w), 128'(0));
        chk("lus_off pc_write", 128'(b_pc_w), 128'(1));
        advance();

        // Jump decode disabled: JAL is a bubble
        apply(0, 1, jal1, 0, 0); advance();
        apply(0, 0, 0, 0, 0);
        chk("jump_on ex_jump", 128'(a_ex_jp), 128'(1));
        chk("jump_off ex_jump", 128'(b_ex_jp), 128'(0));
        chk("jump_off ex_reg_write", 128'(b_ex_rw), 128'(0));
        advance();

        // Saturation of the 4-bit counter under a 20-cycle freeze
        apply(1, 0, 0, 0, 0); advance();
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 0, 1); advance();
        end
        apply(0, 0, 0, 0, 1);
        chk("sat stall_cnt_b", 128'(b_sc), 128'(15));
        chk("sat stall_cnt_a", 128'(a_sc), 128'(20));
        advance();
        apply(0, 0, 0, 0, 0);
        chk("sat hold stall_cnt_b", 128'(b_sc), 128'(15));
        advance();

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            ins = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            ins[31:25] = 7'($urandom);
            ins[14:12] = 3'($urandom);
            apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), ins,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
